fruit_catch_scorer: RTL and testbench
=====================================

Name: fruit_catch_scorer

Overview:
Parametrised collision-and-scoring engine for N falling fruits against one character position. Each frame it snapshots all fruit coordinates and colours on a frame strobe. It then resolves every hit serially, lowest index first, and updates a saturating score. For each caught fruit it emits a one-hot consume pulse so the fruit spawner can retire that fruit.

Parameters:
N_FRUIT, 7, number of fruit channels (1..16)
COORD_W, 7, width of each x/y coordinate
SCORE_W, 8, width of score register (>= 3)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle strobe requesting a hit check for this frame
fruit_x  in  N_FRUIT*COORD_W  packed x coords, fruit i at [i*COORD_W +: COORD_W]
fruit_y  in  N_FRUIT*COORD_W  packed y coords, same packing
fruit_colour  in  N_FRUIT*3  packed 3-bit colours, fruit i at [i*3 +: 3]
fruit_valid  in  N_FRUIT  fruit i currently on screen
char_x  in  COORD_W  character x
char_y  in  COORD_W  character y
busy  out  1  high while not IDLE (combinational from state)
hit  out  1  registered pulse, one per caught fruit
hit_idx  out  clog2(N_FRUIT) (min 1)  index of caught fruit, valid with hit
hit_colour  out  3  colour of caught fruit, valid with hit
consume  out  N_FRUIT  registered one-hot pulse, same cycle as hit
score  out  SCORE_W  running score
frame_done  out  1  registered pulse at end of each frame's resolution
tick_dropped  out  1  registered pulse: frame_tick arrived while busy

Behaviour:
- Reset (synchronous, highest priority, also mid-scan):
  - state=IDLE; score=0.
  - hit, hit_idx, hit_colour, consume, frame_done, tick_dropped all 0.
  - Pending vector and colour snapshot cleared.
- Match rule for fruit i: fruit_valid[i] && x_i==char_x && y_i==char_y && colour_i!=3'b111. Black (111) never matches.
- States: IDLE, SCAN.
- IDLE, frame_tick=1 in cycle T:
  - Register pending = match vector and snapshot all colours.
  - Go to SCAN.
  - Inputs after T are ignored for this frame.
- SCAN, pending!=0:
  - Select lowest set index i; clear pending[i].
  - Register hit=1, hit_idx=i, hit_colour=snap_colour[i], consume=1<<i.
  - Update score.
- SCAN, pending==0:
  - Register frame_done=1; go to IDLE.
- Timing for K hits from tick at cycle T:
  - hit k (k=0..K-1) visible in cycle T+2+k.
  - Score updated in the same cycle as the corresponding hit.
  - frame_done in cycle T+2+K.
  - busy high in cycles T+1..T+1+K.
  - K=0: frame_done in T+2, busy high only in T+1.
- hit, consume, frame_done and tick_dropped are one-cycle pulses, otherwise 0. hit_idx and hit_colour hold their last value.
- Score delta by colour: 000 +1, 001 +2, 010 +3, 011 +4, 100 -1, 101 +5, 110 -2.
- Score arithmetic:
  - Computed at SCORE_W+1 bits, then saturated.
  - Result <0 clamps to 0; result >2^SCORE_W-1 clamps to 2^SCORE_W-1.
  - Score never wraps.
- frame_tick while busy (SCAN) is ignored and does not queue; tick_dropped pulses next cycle.
- A frame_tick in the IDLE cycle that coincides with frame_done output is accepted normally.
- Fruit inputs changing during SCAN do not affect the current frame.
- Multiple fruits at the same coordinate are all caught, one per cycle, in ascending index order.

Test Plan:
- Single hit: reset; fruit 2 at (10,20), colour 010, valid; char (10,20); tick at T -> hit, hit_idx=2, consume=0000100 at T+2; score 0->3; frame_done at T+3.
- Multi-hit ordering: fruits 5, 1, 3 all match, colours 000/011/001 -> hits idx 1,3,5 at T+2,T+3,T+4; score 0->4->6->7; frame_done at T+5.
- Exclusion: matching fruits with colour 111, valid=0, or y mismatch -> no hit; frame_done at T+2; score unchanged.
- Saturation low: score=1, one hit colour 110 -> score 0 (not 255). Saturation high: score=253, colour 101 -> score 255.
- Tick while busy: 3 pending hits, second tick at T+2 -> tick_dropped at T+3; only 3 hits total; no second frame_done.
- Reset mid-scan: reset asserted at T+3 with hits pending -> next cycle score=0, state IDLE, busy=0, no further hit or frame_done.

Source files
------------

// File: rtl/fruit_catch_scorer.sv
// fruit_catch_scorer: per-frame collision check of N falling fruits against the
// character position. On a frame strobe the engine snapshots which fruits hit
// and their colours. It then retires the hits one per cycle, lowest index first,
// and keeps a saturating score. Each caught fruit gets a one-hot consume pulse
// so the spawner can remove it.
module fruit_catch_scorer #(
  parameter int N_FRUIT = 7,
  parameter int COORD_W = 7,
  parameter int SCORE_W = 8,
  localparam int IDX_W  = (N_FRUIT > 1) ? $clog2(N_FRUIT) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic [N_FRUIT*COORD_W-1:0] fruit_x,
  input  logic [N_FRUIT*COORD_W-1:0] fruit_y,
  input  logic [N_FRUIT*3-1:0]       fruit_colour,
  input  logic [N_FRUIT-1:0]         fruit_valid,
  input  logic [COORD_W-1:0]         char_x,
  input  logic [COORD_W-1:0]         char_y,
  output logic                       busy,
  output logic                       hit,
  output logic [IDX_W-1:0]           hit_idx,
  output logic [2:0]                 hit_colour,
  output logic [N_FRUIT-1:0]         consume,
  output logic [SCORE_W-1:0]         score,
  output logic                       frame_done,
  output logic                       tick_dropped
);

  localparam int SW1 = SCORE_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [N_FRUIT-1:0]     pending_q, pending_d;
  logic [N_FRUIT*3-1:0]   snap_colour_q, snap_colour_d;
  logic                   hit_q, hit_d;
  logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
  logic [2:0]             hit_colour_q, hit_colour_d;
  logic [N_FRUIT-1:0]     consume_q, consume_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic                   frame_done_q, frame_done_d;
  logic                   tick_dropped_q, tick_dropped_d;

  logic [N_FRUIT-1:0]     match_vec;
  logic [IDX_W-1:0]       sel_idx;
  logic [2:0]             sel_colour;
  logic [N_FRUIT-1:0]     sel_onehot;
  logic [2:0]             delta_mag;
  logic                   delta_neg;
  logic [SW1-1:0]         score_wide;
  logic [SCORE_W-1:0]     next_score;

  // A fruit is caught when it is on screen, sits exactly on the character and is not black
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < N_FRUIT; i++) begin
      match_vec[i] = fruit_valid[i]
                  && (fruit_x[i*COORD_W +: COORD_W] == char_x)
                  && (fruit_y[i*COORD_W +: COORD_W] == char_y)
                  && (fruit_colour[i*3 +: 3] != 3'b111);
    end
  end

  // Pick the lowest pending index; scanning downwards lets the lowest set bit win
  always_comb begin
    sel_idx    = '0;
    sel_colour = 3'b000;
    sel_onehot = '0;
    for (int i = N_FRUIT - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx    = IDX_W'(i);
        sel_colour = snap_colour_q[i*3 +: 3];
        sel_onehot = N_FRUIT'(1) << i;
      end
    end
  end

  // Colour-to-points table, expressed as magnitude plus sign
  always_comb begin
    delta_mag = 3'd0;
    delta_neg = 1'b0;
    case (sel_colour)
      3'b000: delta_mag = 3'd1;
      3'b001: delta_mag = 3'd2;
      3'b010: delta_mag = 3'd3;
      3'b011: delta_mag = 3'd4;
      3'b100: begin
        delta_mag = 3'd1;
        delta_neg = 1'b1;
      end
      3'b101: delta_mag = 3'd5;
      3'b110: begin
        delta_mag = 3'd2;
        delta_neg = 1'b1;
      end
      default: delta_mag = 3'd0;
    endcase
  end

  // One extra bit catches both overflow (carry) and underflow (borrow), so the score clamps instead of wrapping
  always_comb begin
    score_wide = '0;
    next_score = score_q;
    if (delta_neg) begin
      score_wide = {1'b0, score_q} - SW1'(delta_mag);
      next_score = score_wide[SCORE_W] ? '0 : score_wide[SCORE_W-1:0];
    end else begin
      score_wide = {1'b0, score_q} + SW1'(delta_mag);
      next_score = score_wide[SCORE_W] ? '1 : score_wide[SCORE_W-1:0];
    end
  end

  // Next-state and registered-output logic; pulses default low, hit_idx/hit_colour hold
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    snap_colour_d  = snap_colour_q;
    hit_d          = 1'b0;
    hit_idx_d      = hit_idx_q;
    hit_colour_d   = hit_colour_q;
    consume_d      = '0;
    score_d        = score_q;
    frame_done_d   = 1'b0;
    tick_dropped_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          pending_d     = match_vec;
          snap_colour_d = fruit_colour;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        tick_dropped_d = frame_tick;
        if (|pending_q) begin
          pending_d    = pending_q & ~sel_onehot;
          hit_d        = 1'b1;
          hit_idx_d    = sel_idx;
          hit_colour_d = sel_colour;
          consume_d    = sel_onehot;
          score_d      = next_score;
        end else begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins over everything, including a scan in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      snap_colour_q  <= '0;
      hit_q          <= 1'b0;
      hit_idx_q      <= '0;
      hit_colour_q   <= 3'b000;
      consume_q      <= '0;
      score_q        <= '0;
      frame_done_q   <= 1'b0;
      tick_dropped_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      snap_colour_q  <= snap_colour_d;
      hit_q          <= hit_d;
      hit_idx_q      <= hit_idx_d;
      hit_colour_q   <= hit_colour_d;
      consume_q      <= consume_d;
      score_q        <= score_d;
      frame_done_q   <= frame_done_d;
      tick_dropped_q <= tick_dropped_d;
    end
  end

  assign busy         = (state_q == SCAN);
  assign hit          = hit_q;
  assign hit_idx      = hit_idx_q;
  assign hit_colour   = hit_colour_q;
  assign consume      = consume_q;
  assign score        = score_q;
  assign frame_done   = frame_done_q;
  assign tick_dropped = tick_dropped_q;

endmodule

// File: tb/tb_fruit_catch_scorer.sv
// Testbench for fruit_catch_scorer. A queue-based reference model predicts every
// output each cycle. A table of single-fruit frames, hand-written multi-cycle
// sequences and a randomized run drive the design against that model.
module tb_fruit_catch_scorer;

  localparam int N_FRUIT   = 7;
  localparam int COORD_W   = 7;
  localparam int SCORE_W   = 8;
  localparam int IDX_W     = 3;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       frame_tick;
  logic [N_FRUIT*COORD_W-1:0] fruit_x;
  logic [N_FRUIT*COORD_W-1:0] fruit_y;
  logic [N_FRUIT*3-1:0]       fruit_colour;
  logic [N_FRUIT-1:0]         fruit_valid;
  logic [COORD_W-1:0]         char_x;
  logic [COORD_W-1:0]         char_y;
  logic                       busy;
  logic                       hit;
  logic [IDX_W-1:0]           hit_idx;
  logic [2:0]                 hit_colour;
  logic [N_FRUIT-1:0]         consume;
  logic [SCORE_W-1:0]         score;
  logic                       frame_done;
  logic                       tick_dropped;

  int         fx [N_FRUIT];
  int         fy [N_FRUIT];
  logic [2:0] fc [N_FRUIT];

  // reference model state
  bit                 m_scan;
  int                 m_queue [$];
  logic [2:0]         m_snap [N_FRUIT];
  int                 m_score;
  bit                 m_hit;
  int                 m_idx;
  int                 m_colour;
  logic [N_FRUIT-1:0] m_consume;
  bit                 m_done;
  bit                 m_drop;

  int vectors     = 0;
  int miscompares = 0;
  int hit_count   = 0;
  int done_count  = 0;
  int drop_count  = 0;

  typedef struct {
    int         idx;
    int         x;
    int         y;
    logic [2:0] colour;
    logic       valid;
    int         cx;
    int         cy;
    int         exp_hits;
    int         exp_score;
  } vec_t;

  localparam int NVEC = 9;
  vec_t tbl [NVEC];

  // 10 ns clock
  always #5 clk = ~clk;

  // Pack the per-fruit arrays onto the DUT buses
  always_comb begin
    fruit_x      = '0;
    fruit_y      = '0;
    fruit_colour = '0;
    for (int i = 0; i < N_FRUIT; i++) begin
      fruit_x[i*COORD_W +: COORD_W] = COORD_W'(fx[i]);
      fruit_y[i*COORD_W +: COORD_W] = COORD_W'(fy[i]);
      fruit_colour[i*3 +: 3]        = fc[i];
    end
  end

  fruit_catch_scorer #(
    .N_FRUIT(N_FRUIT),
    .COORD_W(COORD_W),
    .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .fruit_x(fruit_x),
    .fruit_y(fruit_y),
    .fruit_colour(fruit_colour),
    .fruit_valid(fruit_valid),
    .char_x(char_x),
    .char_y(char_y),
    .busy(busy),
    .hit(hit),
    .hit_idx(hit_idx),
    .hit_colour(hit_colour),
    .consume(consume),
    .score(score),
    .frame_done(frame_done),
    .tick_dropped(tick_dropped)
  );

  function automatic int colourPoints(input logic [2:0] c);
    case (c)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 3;
      3'd3:    return 4;
      3'd4:    return -1;
      3'd5:    return 5;
      3'd6:    return -2;
      default: return 0;
    endcase
  endfunction

  function automatic vec_t mkVec(input int idx, input int x, input int y,
                                 input logic [2:0] colour, input logic valid,
                                 input int cx, input int cy,
                                 input int exp_hits, input int exp_score);
    vec_t v;
    v.idx = idx; v.x = x; v.y = y; v.colour = colour; v.valid = valid;
    v.cx = cx; v.cy = cy; v.exp_hits = exp_hits; v.exp_score = exp_score;
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic modelEdge();
    int i;
    m_hit     = 1'b0;
    m_consume = '0;
    m_done    = 1'b0;
    m_drop    = 1'b0;
    if (reset) begin
      m_scan = 1'b0;
      m_queue.delete();
      foreach (m_snap[k]) m_snap[k] = 3'b000;
      m_score  = 0;
      m_idx    = 0;
      m_colour = 0;
    end else if (!m_scan) begin
      if (frame_tick) begin
        m_queue.delete();
        for (int k = 0; k < N_FRUIT; k++) begin
          m_snap[k] = fc[k];
          if (fruit_valid[k] && COORD_W'(fx[k]) == char_x && COORD_W'(fy[k]) == char_y
              && fc[k] != 3'b111)
            m_queue.push_back(k);
        end
        m_scan = 1'b1;
      end
    end else begin
      if (frame_tick) m_drop = 1'b1;
      if (m_queue.size() > 0) begin
        i         = m_queue.pop_front();
        m_hit     = 1'b1;
        m_idx     = i;
        m_colour  = int'(m_snap[i]);
        m_consume = N_FRUIT'(1) << i;
        m_score   = m_score + colourPoints(m_snap[i]);
        if (m_score < 0) m_score = 0;
        if (m_score > SCORE_MAX) m_score = SCORE_MAX;
      end else begin
        m_done = 1'b1;
        m_scan = 1'b0;
      end
    end
  endtask

  task automatic expectVal(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic cmpField(input string name, input int actual, input int expected);
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every DUT output against the model and tally the pulses seen
  task automatic checkOutput();
    vectors++;
    cmpField("busy",         int'(busy),         int'(m_scan));
    cmpField("hit",          int'(hit),          int'(m_hit));
    cmpField("hit_idx",      int'(hit_idx),      m_idx);
    cmpField("hit_colour",   int'(hit_colour),   m_colour);
    cmpField("consume",      int'(consume),      int'(m_consume));
    cmpField("score",        int'(score),        m_score);
    cmpField("frame_done",   int'(frame_done),   int'(m_done));
    cmpField("tick_dropped", int'(tick_dropped), int'(m_drop));
    if (hit)          hit_count++;
    if (frame_done)   done_count++;
    if (tick_dropped) drop_count++;
  endtask

  // One clock: predict, clock, then sample 1 ns after the edge
  task automatic applyStimulus();
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic clearFruits();
    for (int i = 0; i < N_FRUIT; i++) begin
      fx[i] = 0;
      fy[i] = 0;
      fc[i] = 3'b000;
    end
    fruit_valid = '0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
  endtask

  // Strobe one frame and run until frame_done, with a bounded number of cycles
  task automatic runFrame();
    bit seen_done;
    seen_done  = 1'b0;
    frame_tick = 1'b1;
    applyStimulus();
    frame_tick = 1'b0;
    for (int c = 0; c < N_FRUIT + 4; c++) begin
      applyStimulus();
      if (frame_done) begin
        seen_done = 1'b1;
        break;
      end
    end
    if (!seen_done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL frame_timeout: got no frame_done, expected one within %0d cycles",
               N_FRUIT + 4);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    char_x     = '0;
    char_y     = '0;
    clearFruits();

    tbl[0] = mkVec(2,  10,  20, 3'b010, 1'b1,  10,  20, 1, 3);
    tbl[1] = mkVec(0,   5,   5, 3'b111, 1'b1,   5,   5, 0, 3);
    tbl[2] = mkVec(4,   5,   5, 3'b101, 1'b0,   5,   5, 0, 3);
    tbl[3] = mkVec(6,   5,   6, 3'b000, 1'b1,   5,   5, 0, 3);
    tbl[4] = mkVec(6,   5,   5, 3'b100, 1'b1,   5,   5, 1, 2);
    tbl[5] = mkVec(1, 127, 127, 3'b101, 1'b1, 127, 127, 1, 7);
    tbl[6] = mkVec(3,   0,   0, 3'b110, 1'b1,   0,   0, 1, 5);
    tbl[7] = mkVec(5,   9,   4, 3'b011, 1'b1,   4,   9, 0, 5);
    tbl[8] = mkVec(0,   0,   0, 3'b001, 1'b1,   0,   0, 1, 7);

    // reset state
    doReset();
    expectVal("reset_score", int'(score), 0);
    expectVal("reset_busy",  int'(busy),  0);

    // single-fruit frames from the table, score carried across entries
    for (int v = 0; v < NVEC; v++) begin
      clearFruits();
      fx[tbl[v].idx]          = tbl[v].x;
      fy[tbl[v].idx]          = tbl[v].y;
      fc[tbl[v].idx]          = tbl[v].colour;
      fruit_valid[tbl[v].idx] = tbl[v].valid;
      char_x = COORD_W'(tbl[v].cx);
      char_y = COORD_W'(tbl[v].cy);
      hit_count = 0;
      runFrame();
      expectVal($sformatf("tbl%0d_hits", v),  hit_count,   tbl[v].exp_hits);
      expectVal($sformatf("tbl%0d_score", v), int'(score), tbl[v].exp_score);
    end

    // multi-hit ordering; fruit inputs scrambled after the tick must not matter
    doReset();
    clearFruits();
    fx[5] = 30; fy[5] = 40; fc[5] = 3'b000;
    fx[1] = 30; fy[1] = 40; fc[1] = 3'b011;
    fx[3] = 30; fy[3] = 40; fc[3] = 3'b001;
    fruit_valid = 7'b0101010;
    char_x = 7'd30; char_y = 7'd40;
    frame_tick = 1'b1;
    applyStimulus();
    frame_tick = 1'b0;
    expectVal("multi_busy_t1", int'(busy), 1);
    for (int i = 0; i < N_FRUIT; i++) fc[i] = 3'b111;
    fruit_valid = '0;
    applyStimulus();
    expectVal("multi_idx_t2",   int'(hit_idx), 1);
    expectVal("multi_score_t2", int'(score),   4);
    expectVal("multi_cons_t2",  int'(consume), 2);
    applyStimulus();
    expectVal("multi_idx_t3",   int'(hit_idx), 3);
    expectVal("multi_score_t3", int'(score),   6);
    applyStimulus();
    expectVal("multi_idx_t4",   int'(hit_idx), 5);
    expectVal("multi_score_t4", int'(score),   7);
    expectVal("multi_cons_t4",  int'(consume), 32);
    applyStimulus();
    expectVal("multi_done_t5",  int'(frame_done), 1);
    expectVal("multi_busy_t5",  int'(busy),       0);

    // saturation at zero
    doReset();
    clearFruits();
    fx[0] = 1; fy[0] = 1; fc[0] = 3'b000; fruit_valid = 7'b0000001;
    char_x = 7'd1; char_y = 7'd1;
    runFrame();
    expectVal("satlo_score1", int'(score), 1);
    fc[0] = 3'b110;
    runFrame();
    expectVal("satlo_score0", int'(score), 0);

    // saturation at the top: 7 frames of 7x(+5) = 245, then +5+3 = 253
    doReset();
    clearFruits();
    for (int i = 0; i < N_FRUIT; i++) begin
      fx[i] = 2; fy[i] = 2; fc[i] = 3'b101;
    end
    fruit_valid = '1;
    char_x = 7'd2; char_y = 7'd2;
    for (int f = 0; f < 7; f++) runFrame();
    expectVal("sathi_245", int'(score), 245);
    fc[1] = 3'b010;
    fruit_valid = 7'b0000011;
    runFrame();
    expectVal("sathi_253", int'(score), 253);
    fruit_valid = 7'b0000001;
    runFrame();
    expectVal("sathi_255", int'(score), 255);
    runFrame();
    expectVal("sathi_hold", int'(score), 255);

    // frame_tick while scanning is dropped and does not queue another frame
    doReset();
    clearFruits();
    fx[0] = 3; fy[0] = 3;
    fx[2] = 3; fy[2] = 3;
    fx[4] = 3; fy[4] = 3;
    fruit_valid = 7'b0010101;
    char_x = 7'd3; char_y = 7'd3;
    hit_count = 0; done_count = 0; drop_count = 0;
    frame_tick = 1'b1;
    applyStimulus();
    frame_tick = 1'b0;
    applyStimulus();
    frame_tick = 1'b1;
    applyStimulus();
    frame_tick = 1'b0;
    expectVal("drop_pulse", int'(tick_dropped), 1);
    for (int c = 0; c < 6; c++) applyStimulus();
    expectVal("drop_hits",  hit_count,  3);
    expectVal("drop_dones", done_count, 1);
    expectVal("drop_count", drop_count, 1);

    // reset in the middle of a scan
    doReset();
    clearFruits();
    for (int i = 0; i < 4; i++) begin
      fx[i] = 8; fy[i] = 9; fc[i] = 3'b000;
    end
    fruit_valid = 7'b0001111;
    char_x = 7'd8; char_y = 7'd9;
    frame_tick = 1'b1;
    applyStimulus();
    frame_tick = 1'b0;
    applyStimulus();
    applyStimulus();
    expectVal("rst_mid_score_before", int'(score), 2);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    expectVal("rst_mid_score", int'(score), 0);
    expectVal("rst_mid_busy",  int'(busy),  0);
    expectVal("rst_mid_hit",   int'(hit),   0);
    hit_count = 0; done_count = 0;
    for (int c = 0; c < 5; c++) applyStimulus();
    expectVal("rst_mid_no_hits", hit_count,  0);
    expectVal("rst_mid_no_done", done_count, 0);

    // randomized traffic on a small grid so collisions are common
    doReset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N_FRUIT; i++) begin
        fx[i] = $urandom_range(0, 2);
        fy[i] = $urandom_range(0, 2);
        fc[i] = 3'($urandom_range(0, 7));
      end
      fruit_valid = N_FRUIT'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        char_x = COORD_W'($urandom_range(0, 2));
        char_y = COORD_W'($urandom_range(0, 2));
      end
      frame_tick = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      applyStimulus();
    end
    reset      = 1'b0;
    frame_tick = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
